// File: rtl/uart_tx_ctrl_if.sv
// Byte-request / serial-line bundle between a UART transmit client and the frame controller.
interface uart_tx_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  Data_Valid;
    logic                  PAR_EN;
    logic                  par_bit;
    logic                  TX_OUT;
    logic                  Busy;

    modport master (
        output P_DATA,
        output Data_Valid,
        output PAR_EN,
        output par_bit,
        input  TX_OUT,
        input  Busy
    );

    modport slave (
        input  P_DATA,
        input  Data_Valid,
        input  PAR_EN,
        input  par_bit,
        output TX_OUT,
        output Busy
    );
endinterface

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame controller: start bit, LSB-first data, optional parity, stop bit.
// Line and busy outputs come straight from flops loaded with next-state values.
module uart_tx_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic           CLK,
    input  logic           RST,
    uart_tx_ctrl_if.slave  bus
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    logic [2:0]            state_r;
    logic [2:0]            next_state_s;
    logic [DATA_WIDTH-1:0] shift_r;
    logic [CNT_W-1:0]      cnt_r;
    logic                  par_r;
    logic                  par_en_r;
    logic                  tx_out_r;
    logic                  busy_r;
    logic                  tx_next_s;
    logic                  busy_next_s;
    logic                  load_s;

    // Next-state decode plus the line/busy values that belong to the next state
    always_comb begin
        next_state_s = state_r;
        load_s       = 1'b0;
        tx_next_s    = 1'b1;
        busy_next_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.Data_Valid) begin
                    next_state_s = START;
                    load_s       = 1'b1;
                end else begin
                    next_state_s = IDLE;
                end
            end
            START:  next_state_s = DATA;
            DATA: begin
                if (cnt_r == CNT_LAST) begin
                    next_state_s = par_en_r ? PARITY : STOP;
                end else begin
                    next_state_s = DATA;
                end
            end
            PARITY: next_state_s = STOP;
            STOP: begin
                if (bus.Data_Valid) begin
                    next_state_s = START;
                    load_s       = 1'b1;
                end else begin
                    next_state_s = IDLE;
                end
            end
            default: next_state_s = IDLE;
        endcase

        // shift_r[0] is always the next data bit to present, so DATA can use it directly
        case (next_state_s)
            START: begin
                tx_next_s   = 1'b0;
                busy_next_s = 1'b1;
            end
            DATA: begin
                tx_next_s   = shift_r[0];
                busy_next_s = 1'b1;
            end
            PARITY: begin
                tx_next_s   = par_r;
                busy_next_s = 1'b1;
            end
            STOP: begin
                tx_next_s   = 1'b1;
                busy_next_s = 1'b1;
            end
            default: begin
                tx_next_s   = 1'b1;
                busy_next_s = 1'b0;
            end
        endcase
    end

    // Frame state, datapath registers and registered line outputs
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_r  <= IDLE;
            shift_r  <= '0;
            cnt_r    <= '0;
            par_r    <= 1'b0;
            par_en_r <= 1'b0;
            tx_out_r <= 1'b1;
            busy_r   <= 1'b0;
        end else begin
            state_r  <= next_state_s;
            tx_out_r <= tx_next_s;
            busy_r   <= busy_next_s;

            if (load_s) begin
                shift_r  <= bus.P_DATA;
                par_en_r <= bus.PAR_EN;
            end else if ((state_r == START) || (state_r == DATA)) begin
                shift_r  <= {1'b0, shift_r[DATA_WIDTH-1:1]};
            end else begin
                shift_r  <= shift_r;
            end

            // Parity is frozen once per frame; later par_bit activity cannot reach the line
            if (state_r == START) begin
                par_r <= bus.par_bit;
            end else begin
                par_r <= par_r;
            end

            if ((state_r == DATA) && (cnt_r != CNT_LAST)) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end else begin
                cnt_r <= '0;
            end
        end
    end

    assign bus.TX_OUT = tx_out_r;
    assign bus.Busy   = busy_r;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: table of single frames plus hand sequences for
// back-to-back, ignored strobes and reset corner cases.
module tb_uart_tx_ctrl;

    logic CLK;
    logic RST;

    uart_tx_ctrl_if #(.DATA_WIDTH(8)) bus ();

    uart_tx_ctrl #(.DATA_WIDTH(8)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0]  data;
        logic        pe;
        logic        pb;
        logic [0:11] exp_tx;    // line value in c1..c12, time order left to right
        int          busy_len;  // Busy expected high in c1..c<busy_len>
    } vec_t;

    vec_t vecs [5];
    int   n_checks;
    int   n_fail;

    task automatic chk(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Checks n consecutive cycles starting with the current one, then leaves us in the next
    task automatic check_seq(input logic [0:31] exp, input int n, input int busy_len, input string tag);
        for (int k = 0; k < n; k++) begin
            chk($sformatf("%s_tx_%0d", tag, k), bus.TX_OUT, exp[k]);
            chk($sformatf("%s_busy_%0d", tag, k), bus.Busy, (k < busy_len) ? 1'b1 : 1'b0);
            step();
        end
    endtask

    // Presents one strobe; returns positioned #1 into c1 with par_bit applied
    task automatic launch(input logic [7:0] data, input logic pe, input logic pb);
        @(negedge CLK);
        bus.P_DATA     = data;
        bus.PAR_EN     = pe;
        bus.Data_Valid = 1'b1;
        step();
        bus.Data_Valid = 1'b0;
        bus.par_bit    = pb;
    endtask

    task automatic run_vec(input int i);
        launch(vecs[i].data, vecs[i].pe, vecs[i].pb);
        check_seq({vecs[i].exp_tx, 20'd0}, 12, vecs[i].busy_len, $sformatf("vec%0d", i));
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;

        vecs[0] = '{data: 8'hA5, pe: 1'b1, pb: 1'b0, exp_tx: 12'b010100101011, busy_len: 11};
        vecs[1] = '{data: 8'h0F, pe: 1'b0, pb: 1'b0, exp_tx: 12'b011110000111, busy_len: 10};
        vecs[2] = '{data: 8'h3C, pe: 1'b1, pb: 1'b0, exp_tx: 12'b000111100011, busy_len: 11};
        vecs[3] = '{data: 8'h01, pe: 1'b1, pb: 1'b1, exp_tx: 12'b010000000111, busy_len: 11};
        vecs[4] = '{data: 8'h55, pe: 1'b0, pb: 1'b0, exp_tx: 12'b010101010111, busy_len: 10};

        RST            = 1'b0;
        bus.P_DATA     = 8'h00;
        bus.Data_Valid = 1'b0;
        bus.PAR_EN     = 1'b0;
        bus.par_bit    = 1'b0;
        step();
        step();
        step();
        chk("reset_tx", bus.TX_OUT, 1'b1);
        chk("reset_busy", bus.Busy, 1'b0);
        RST = 1'b1;
        step();
        chk("idle_tx", bus.TX_OUT, 1'b1);
        chk("idle_busy", bus.Busy, 1'b0);

        for (int i = 0; i < 5; i++) begin
            run_vec(i);
            step();
        end

        // Back-to-back: new strobe during the STOP cycle of 0x3C starts 0x81 with no gap
        launch(8'h3C, 1'b1, 1'b0);
        check_seq({10'b0001111000, 22'd0}, 10, 10, "b2b_f1");
        chk("b2b_stop_tx", bus.TX_OUT, 1'b1);
        chk("b2b_stop_busy", bus.Busy, 1'b1);
        bus.P_DATA     = 8'h81;
        bus.PAR_EN     = 1'b1;
        bus.Data_Valid = 1'b1;
        step();
        bus.Data_Valid = 1'b0;
        bus.par_bit    = 1'b0;
        check_seq({12'b010000001011, 20'd0}, 12, 11, "b2b_f2");

        // Strobe mid-frame with different data, parity enable and parity input
        step();
        launch(8'hA5, 1'b1, 1'b0);
        check_seq({3'b010, 29'd0}, 3, 3, "ign_a");
        bus.P_DATA     = 8'hFF;
        bus.PAR_EN     = 1'b0;
        bus.Data_Valid = 1'b1;
        bus.par_bit    = 1'b1;
        check_seq({1'b1, 31'd0}, 1, 1, "ign_b");
        bus.Data_Valid = 1'b0;
        bus.par_bit    = 1'b0;
        check_seq({3'b001, 29'd0}, 3, 3, "ign_c");
        bus.par_bit    = 1'b1;
        check_seq({7'b0101111, 25'd0}, 7, 4, "ign_d");
        bus.par_bit    = 1'b0;

        // Reset during data bit 3 aborts the frame
        launch(8'hA5, 1'b1, 1'b0);
        check_seq({4'b0101, 28'd0}, 4, 4, "rmid_a");
        RST = 1'b0;
        step();
        RST = 1'b1;
        check_seq({3'b111, 29'd0}, 3, 0, "rmid_b");
        run_vec(4);

        // Reset wins over a simultaneous strobe
        step();
        RST            = 1'b0;
        bus.P_DATA     = 8'h55;
        bus.PAR_EN     = 1'b1;
        bus.Data_Valid = 1'b1;
        step();
        RST            = 1'b1;
        bus.Data_Valid = 1'b0;
        check_seq({3'b111, 29'd0}, 3, 0, "rdv");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_ctrl.md
# uart_tx_ctrl

Frame controller for the UART transmitter. It accepts a parallel byte on a single-cycle `Data_Valid` strobe and sequences the serial frame: start bit, 8 data bits LSB-first, optional parity bit, stop bit. It owns the frame FSM, the data shift register and the bit counter, and it drives the line output. The parity bit comes from the team's registered parity calculator, which is fed the same `P_DATA`/`Data_Valid`. The controller latches that bit so later strobes cannot corrupt a frame in flight.

## Interface
- `DATA_WIDTH`, default 8: number of data bits per frame.
- `CLK`  in  1: single clock; all state updates on its rising edge.
- `RST`  in  1: synchronous, active-low reset, sampled on the `CLK` rising edge.
- `P_DATA`  in  DATA_WIDTH: byte to transmit; sampled only when a frame is accepted.
- `Data_Valid`  in  1: single-cycle request strobe; honoured only in IDLE or STOP.
- `PAR_EN`  in  1: parity bit included when 1; sampled with `P_DATA` at acceptance.
- `par_bit`  in  1: parity from the parity calculator; valid the cycle after acceptance.
- `TX_OUT`  out  1: serial line; idle level 1; driven directly from a flop.
- `Busy`  out  1: 1 from the start bit through the stop bit; driven directly from a flop.

## Operation
- States: IDLE, START, DATA, PARITY, STOP. Encoding is free; it must be the registered state.
- IDLE: `TX_OUT`=1, `Busy`=0.
  - `Data_Valid`=1: load the shift register with `P_DATA`, latch `PAR_EN` into `par_en_q`, go to START.
- START: `TX_OUT`=0, `Busy`=1.
  - Capture `par_bit` into `par_q` in this cycle.
  - Go to DATA and clear the bit counter.
- DATA: `TX_OUT`=shift register bit 0, then shift right.
  - The counter runs 0..DATA_WIDTH-1.
  - At count DATA_WIDTH-1, go to PARITY if `par_en_q`=1, otherwise go to STOP.
- PARITY: `TX_OUT`=`par_q`. Go to STOP.
- STOP: `TX_OUT`=1, `Busy`=1.
  - `Data_Valid`=1 in this cycle: accept a new frame exactly as in IDLE and go straight to START, with no idle gap.
  - Otherwise go to IDLE.
- `Data_Valid` in START, DATA or PARITY is ignored. `P_DATA`, `PAR_EN` and `par_bit` changes in those states have no effect on the current frame.
- The counter width is $clog2(DATA_WIDTH). It never wraps past DATA_WIDTH-1 and holds 0 outside DATA.
- Reset (`RST`=0 at an edge): state=IDLE, `TX_OUT`=1, `Busy`=0, counter=0, shift register=0, `par_q`=0, `par_en_q`=0.
  - This applies from any state, including mid-frame. The frame is aborted and no stop bit is sent.
  - Reset has priority over a simultaneous `Data_Valid`.

## Timing
- Cycle c0 is the cycle with `Data_Valid`=1, accepted in IDLE or STOP.
- After the c0 edge: `TX_OUT`=0 (start bit) and `Busy`=1 during c1.
- Data bit i is on `TX_OUT` during cycle c2+i, for i=0..7.
- Parity enabled: parity in c10, stop in c11, frame length 11 cycles. Parity disabled: stop in c10, frame length 10 cycles.
- `Busy` falls, and `TX_OUT` stays 1, in the cycle after STOP unless a new frame was accepted in STOP.
- `par_bit` must be valid during c1. The parity calculator registers on the c0 edge, so this holds by construction.
- Each line bit lasts exactly one `CLK` cycle. Baud-rate division is done upstream via the clock or its enable.
- `TX_OUT` and `Busy` change only on `CLK` edges. They are glitch-free.

## Test plan
- **Parity frame:** reset, then `P_DATA`=0xA5, `PAR_EN`=1, one-cycle `Data_Valid`, `par_bit`=0 from c1 → `TX_OUT` c1..c11 = 0,1,0,1,0,0,1,0,1,0,1. `Busy`=1 for exactly c1..c11, then 0.
- **No-parity frame:** `P_DATA`=0x0F, `PAR_EN`=0 → `TX_OUT` c1..c10 = 0,1,1,1,1,0,0,0,0,1. `Busy` high 10 cycles; `TX_OUT`=1 afterwards.
- **Back-to-back:** frame 0x3C with `PAR_EN`=1, then `Data_Valid` with 0x81 in its STOP cycle → second start bit in the very next cycle. `Busy` stays 1 continuously and both frames are bit-exact.
- **Ignored strobe mid-frame:** during DATA of 0xA5, pulse `Data_Valid` with 0xFF, `PAR_EN`=0, and toggle `par_bit` → the 0xA5 frame and its parity bit 0 are unchanged. Return to IDLE with no second frame.
- **Reset mid-frame:** `RST`=0 for one cycle at data bit 3 → next cycle `TX_OUT`=1, `Busy`=0, IDLE. A fresh 0x55 request afterwards produces a correct full frame.
- **Reset with `Data_Valid`:** `RST`=0 together with `Data_Valid`=1 → no frame starts; `TX_OUT` stays 1.
